fc_argmax_reader: RTL and testbench



---
 rtl/fc_argmax_reader.sv | 154 +++++++++++++++
 tb/tb_fc_argmax_reader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_reader.sv
// Sequential argmax over the final FC scores (optional FC_ARGMAX_TOP2_EN adds runner-up tracking).
// Latency: result and oDone are valid 9 enabled cycles after the iStart rising edge is sampled.
// Backpressure: none; ena=0 freezes everything, and starts seen during a scan are dropped.
module fc_argmax_reader #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16
) (
    input  logic                           clk,
    input  logic                           iRst,
    input  logic                           ena,
    input  logic                           iStart,
    input  logic [NUM_CLASSES*SCORE_W-1:0] iScores,
    output logic                           oBusy,
    output logic                           oDone,
    output logic [3:0]                     oDigit,
    output logic [SCORE_W-1:0]             oScore
`ifdef FC_ARGMAX_TOP2_EN
    ,
    output logic [3:0]                     oSecondDigit,
    output logic [SCORE_W-1:0]             oSecondScore
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    state_t                     state, state_nxt;
    logic                       start_d;
    logic                       start_edge;
    logic                       load;
    logic [3:0]                 idx, idx_nxt;
    logic signed [SCORE_W-1:0]  score_q [NUM_CLASSES];
    logic signed [SCORE_W-1:0]  cur;
    logic signed [SCORE_W-1:0]  best, best_nxt;
    logic [3:0]                 best_idx, best_idx_nxt;
    logic                       busy_nxt, done_nxt;
    logic [3:0]                 digit_nxt;
    logic [SCORE_W-1:0]         score_nxt;
`ifdef FC_ARGMAX_TOP2_EN
    logic signed [SCORE_W-1:0]  second, second_nxt;
    logic [3:0]                 second_idx, second_idx_nxt;
    logic [3:0]                 sdigit_nxt;
    logic [SCORE_W-1:0]         sscore_nxt;
`endif

    assign start_edge = iStart & ~start_d;
    assign cur        = score_q[idx];

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        best_nxt     = best;
        best_idx_nxt = best_idx;
        busy_nxt     = oBusy;
        done_nxt     = oDone;
        digit_nxt    = oDigit;
        score_nxt    = oScore;
        load         = 1'b0;
`ifdef FC_ARGMAX_TOP2_EN
        second_nxt     = second;
        second_idx_nxt = second_idx;
        sdigit_nxt     = oSecondDigit;
        sscore_nxt     = oSecondScore;
`endif
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    load         = 1'b1;
                    state_nxt    = SCAN;
                    idx_nxt      = 4'd1;
                    best_nxt     = iScores[SCORE_W-1:0];
                    best_idx_nxt = 4'd0;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
`ifdef FC_ARGMAX_TOP2_EN
                    second_nxt     = {1'b1, {(SCORE_W-1){1'b0}}};
                    second_idx_nxt = 4'd0;
`endif
                end
            end
            SCAN: begin
                // Strict compares: on any tie the earlier (lower) index is kept.
                if (cur > best) begin
                    best_nxt     = cur;
                    best_idx_nxt = idx;
`ifdef FC_ARGMAX_TOP2_EN
                    second_nxt     = best;
                    second_idx_nxt = best_idx;
                end else if (cur > second) begin
                    second_nxt     = cur;
                    second_idx_nxt = idx;
`endif
                end
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    digit_nxt = best_idx_nxt;
                    score_nxt = best_nxt;
`ifdef FC_ARGMAX_TOP2_EN
                    sdigit_nxt = second_idx_nxt;
                    sscore_nxt = second_nxt;
`endif
                end else begin
                    idx_nxt = idx + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            start_d  <= 1'b0;
            idx      <= 4'd0;
            best     <= '0;
            best_idx <= 4'd0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            oDigit   <= 4'd0;
            oScore   <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) score_q[i] <= '0;
`ifdef FC_ARGMAX_TOP2_EN
            second       <= '0;
            second_idx   <= 4'd0;
            oSecondDigit <= 4'd0;
            oSecondScore <= '0;
`endif
        end else if (ena) begin
            state    <= state_nxt;
            start_d  <= iStart;
            idx      <= idx_nxt;
            best     <= best_nxt;
            best_idx <= best_idx_nxt;
            oBusy    <= busy_nxt;
            oDone    <= done_nxt;
            oDigit   <= digit_nxt;
            oScore   <= score_nxt;
            if (load) begin
                for (int i = 0; i < NUM_CLASSES; i++)
                    score_q[i] <= iScores[i*SCORE_W +: SCORE_W];
            end
`ifdef FC_ARGMAX_TOP2_EN
            second       <= second_nxt;
            second_idx   <= second_idx_nxt;
            oSecondDigit <= sdigit_nxt;
            oSecondScore <= sscore_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Scoreboard bench for fc_argmax_reader: stimulus pushes expected results, a negedge monitor checks each oDone rise.
module tb_fc_argmax_reader;

    logic         clk = 1'b0;
    logic         iRst = 1'b1;
    logic         ena = 1'b1;
    logic         iStart = 1'b0;
    logic [159:0] iScores = '0;
    logic         oBusy, oDone;
    logic [3:0]   oDigit;
    logic [15:0]  oScore;
`ifdef FC_ARGMAX_TOP2_EN
    logic [3:0]   oSecondDigit;
    logic [15:0]  oSecondScore;
`endif

    fc_argmax_reader dut (
        .clk(clk), .iRst(iRst), .ena(ena), .iStart(iStart), .iScores(iScores),
        .oBusy(oBusy), .oDone(oDone), .oDigit(oDigit), .oScore(oScore)
`ifdef FC_ARGMAX_TOP2_EN
        , .oSecondDigit(oSecondDigit), .oSecondScore(oSecondScore)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d;
        logic [15:0] s;
        logic [3:0]  d2;
        logic [15:0] s2;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        else
            n_pass++;
    endtask

    // Monitor: every oDone rise consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!iRst && oDone && !prev_done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("digit", {28'd0, oDigit}, {28'd0, e.d});
                check("score", {16'd0, oScore}, {16'd0, e.s});
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", {31'd0, oBusy}, 32'd0);
`ifdef FC_ARGMAX_TOP2_EN
                check("second_digit", {28'd0, oSecondDigit}, {28'd0, e.d2});
                check("second_score", {16'd0, oSecondScore}, {16'd0, e.s2});
`endif
            end
        end
        prev_done = oDone;
    end

    function automatic logic [159:0] pack(input logic [15:0] v [10]);
        logic [159:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[i*16 +: 16] = v[i];
        return r;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            q.delete();
        end
    endtask

    // Launch a scan with a fresh low->high edge; optional stall of stall_len cycles after stall_at cycles.
    task automatic run_scan(input string name, input logic [159:0] sc, input exp_t e,
                            input int stall_at, input int stall_len, input logic [159:0] alt);
        @(negedge clk);
        iStart = 1'b0;
        @(negedge clk);
        iScores = sc;
        iStart  = 1'b1;
        e.cyc   = cyc + 10 + stall_len;
        q.push_back(e);
        @(negedge clk);
        check({name, "_busy_after_start"}, {31'd0, oBusy}, 32'd1);
        check({name, "_done_cleared"}, {31'd0, oDone}, 32'd0);
        iScores = alt;
        if (stall_len > 0) begin
            repeat (stall_at) @(negedge clk);
            ena = 1'b0;
            repeat (stall_len) @(negedge clk);
            ena = 1'b1;
        end
        wait_drain(name);
    endtask

    initial begin
        logic [15:0] v [10];
        logic [159:0] sc_asc, sc_neg, sc_tie, sc_stall, sc_desc, sc_five, sc_junk;
        exp_t e;

        for (int i = 0; i < 10; i++) v[i] = 16'(i * 256);
        sc_asc = pack(v);
        for (int i = 0; i < 10; i++) v[i] = 16'hFF00;
        v[3] = 16'hFFF0;
        sc_neg = pack(v);
        for (int i = 0; i < 10; i++) v[i] = 16'h0000;
        v[2] = 16'h7FFF; v[7] = 16'h7FFF;
        sc_tie = pack(v);
        for (int i = 0; i < 10; i++) v[i] = 16'h0010;
        v[4] = 16'h1234; v[6] = 16'h1000;
        sc_stall = pack(v);
        for (int i = 0; i < 10; i++) v[i] = 16'((9 - i) * 256);
        sc_desc = pack(v);
        for (int i = 0; i < 10; i++) v[i] = 16'hFFFF;
        v[5] = 16'h0500;
        sc_five = pack(v);
        for (int i = 0; i < 10; i++) v[i] = 16'h7000;
        sc_junk = pack(v);

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, oBusy}, 32'd0);
        check("rst_done", {31'd0, oDone}, 32'd0);
        check("rst_digit", {28'd0, oDigit}, 32'd0);
        check("rst_score", {16'd0, oScore}, 32'd0);
        iRst = 1'b0;

        e = '{d: 4'd9, s: 16'h0900, d2: 4'd8, s2: 16'h0800, cyc: 0};
        run_scan("ascending", sc_asc, e, 0, 0, sc_asc);
        e = '{d: 4'd3, s: 16'hFFF0, d2: 4'd0, s2: 16'hFF00, cyc: 0};
        run_scan("negative", sc_neg, e, 0, 0, sc_neg);
        e = '{d: 4'd2, s: 16'h7FFF, d2: 4'd7, s2: 16'h7FFF, cyc: 0};
        run_scan("tie", sc_tie, e, 0, 0, sc_tie);
        e = '{d: 4'd4, s: 16'h1234, d2: 4'd6, s2: 16'h1000, cyc: 0};
        run_scan("stall", sc_stall, e, 3, 3, sc_junk);

        // Reset in the middle of a scan, iStart held high through release.
        @(negedge clk);
        iStart = 1'b0;
        @(negedge clk);
        iScores = sc_asc;
        iStart  = 1'b1;
        repeat (5) @(negedge clk);
        check("midscan_busy", {31'd0, oBusy}, 32'd1);
        iRst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, oBusy}, 32'd0);
        check("midrst_done", {31'd0, oDone}, 32'd0);
        check("midrst_digit", {28'd0, oDigit}, 32'd0);
        check("midrst_score", {16'd0, oScore}, 32'd0);
`ifdef FC_ARGMAX_TOP2_EN
        check("midrst_sdigit", {28'd0, oSecondDigit}, 32'd0);
        check("midrst_sscore", {16'd0, oSecondScore}, 32'd0);
`endif
        iScores = sc_desc;
        repeat (2) @(negedge clk);
        iRst = 1'b0;
        e = '{d: 4'd0, s: 16'h0900, d2: 4'd1, s2: 16'h0800, cyc: cyc + 10};
        q.push_back(e);
        wait_drain("reset_restart");

        e = '{d: 4'd5, s: 16'h0500, d2: 4'd0, s2: 16'hFFFF, cyc: 0};
        run_scan("restart", sc_five, e, 0, 0, sc_junk);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
